// File: rtl/leds_pwm_pio_pkg.sv
// Shared constants for the LED PWM PIO: register word addresses and parameter defaults.
package leds_pwm_pio_pkg;

  localparam int DEF_WIDTH    = 14;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_PRESCALE = 16;
  localparam int BLINK_W      = 16;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_RSVD       = 3'd1;
  localparam logic [2:0] ADDR_SET        = 3'd2;
  localparam logic [2:0] ADDR_CLEAR      = 3'd3;
  localparam logic [2:0] ADDR_DUTY       = 3'd4;
  localparam logic [2:0] ADDR_BLINK_MASK = 3'd5;
  localparam logic [2:0] ADDR_BLINK_HALF = 3'd6;
  localparam logic [2:0] ADDR_STATUS     = 3'd7;

endpackage

// File: rtl/leds_pwm_timebase.sv
// PWM timebase: prescaler producing a count tick, and the PWM counter whose wrap marks frame end.
module leds_pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  output logic [PWM_BITS-1:0] o_pwm_cnt,
  output logic                o_tick,
  output logic                o_frame_end
);

  localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  logic [PS_W-1:0]     r_presc;
  logic [PWM_BITS-1:0] r_pwm_cnt;

  assign o_tick      = (r_presc == PS_LAST);
  assign o_frame_end = o_tick && (r_pwm_cnt == '1);
  assign o_pwm_cnt   = r_pwm_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_presc <= o_tick ? '0 : r_presc + 1'b1;
      if (o_tick) r_pwm_cnt <= r_pwm_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/leds_pwm_pio.sv
// Avalon-MM LED PIO with global PWM dimming and optional per-bit blinking.
// Blink logic is built only when LEDS_PWM_PIO_BLINK_EN is defined.
module leds_pwm_pio
  import leds_pwm_pio_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int PRESCALE = DEF_PRESCALE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0]    r_data;
  logic [PWM_BITS-1:0] r_duty_pend;
  logic [PWM_BITS-1:0] r_duty_act;
  logic [WIDTH-1:0]    r_out;
  logic                r_frame_seen;

  logic [PWM_BITS-1:0] w_pwm_cnt;
  logic                w_tick;
  logic                w_frame_end;
  logic                w_wr;
  logic                w_pwm_on;
  logic [WIDTH-1:0]    w_wd;
  logic [WIDTH-1:0]    w_blink_mask;
  logic [BLINK_W-1:0]  w_blink_half;
  logic                w_blink_phase;
  logic                w_unused;

  leds_pwm_timebase #(
    .PWM_BITS (PWM_BITS),
    .PRESCALE (PRESCALE)
  ) u_timebase (
    .i_clk       (clk),
    .i_rst_n     (reset_n),
    .o_pwm_cnt   (w_pwm_cnt),
    .o_tick      (w_tick),
    .o_frame_end (w_frame_end)
  );

  assign w_wr     = chipselect && !write_n;
  assign w_wd     = writedata[WIDTH-1:0];
  assign w_unused = &{1'b0, writedata, w_tick};

  // Full-scale duty is forced on so 100% has no one-count dark gap.
  assign w_pwm_on = (r_duty_act == '1) || (w_pwm_cnt < r_duty_act);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data       <= '0;
      r_duty_pend  <= '0;
      r_duty_act   <= '0;
      r_frame_seen <= 1'b0;
      r_out        <= '0;
    end else begin
      if (w_wr) begin
        case (address)
          ADDR_DATA:  r_data <= w_wd;
          ADDR_SET:   r_data <= r_data | w_wd;
          ADDR_CLEAR: r_data <= r_data & ~w_wd;
          ADDR_DUTY:  r_duty_pend <= writedata[PWM_BITS-1:0];
          default:    ;
        endcase
      end
      // Duty only changes at frame boundaries so a frame is never cut short.
      if (w_frame_end) r_duty_act <= r_duty_pend;
      if (w_frame_end) r_frame_seen <= 1'b1;
      else if (w_wr && address == ADDR_STATUS) r_frame_seen <= 1'b0;
      r_out <= r_data & {WIDTH{w_pwm_on}} & ~(w_blink_mask & {WIDTH{w_blink_phase}});
    end
  end

`ifdef LEDS_PWM_PIO_BLINK_EN
  logic [WIDTH-1:0]   r_blink_mask;
  logic [BLINK_W-1:0] r_blink_half;
  logic [BLINK_W-1:0] r_frame_cnt;
  logic               r_blink_phase;
  logic [BLINK_W-1:0] w_frame_cnt_nxt;

  assign w_frame_cnt_nxt = r_frame_cnt + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_blink_mask  <= '0;
      r_blink_half  <= '0;
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_wr && address == ADDR_BLINK_MASK) r_blink_mask <= w_wd;
      if (w_wr && address == ADDR_BLINK_HALF) begin
        r_blink_half  <= writedata[BLINK_W-1:0];
        r_frame_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (r_blink_half == '0) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= 1'b0;
      end else if (w_frame_end) begin
        if (w_frame_cnt_nxt == r_blink_half) begin
          r_frame_cnt   <= '0;
          r_blink_phase <= ~r_blink_phase;
        end else begin
          r_frame_cnt <= w_frame_cnt_nxt;
        end
      end
    end
  end

  assign w_blink_mask  = r_blink_mask;
  assign w_blink_half  = r_blink_half;
  assign w_blink_phase = r_blink_phase;
`else
  assign w_blink_mask  = '0;
  assign w_blink_half  = '0;
  assign w_blink_phase = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:       readdata = 32'(r_data);
      ADDR_DUTY:       readdata = 32'(r_duty_pend);
      ADDR_BLINK_MASK: readdata = 32'(w_blink_mask);
      ADDR_BLINK_HALF: readdata = 32'(w_blink_half);
      ADDR_STATUS:     readdata = {30'b0, r_frame_seen, w_blink_phase};
      default:         readdata = '0;
    endcase
  end

  assign out_port = r_out;

endmodule

// File: doc/leds_pwm_pio.md
LEDS_PWM_PIO -- requirements
Module: leds_pwm_pio

Interface
REQ-001 Parameter WIDTH, default 14, number of output bits (1..32).
REQ-002 Parameter PWM_BITS, default 8, PWM counter width (2..16).
REQ-003 Parameter PRESCALE, default 16, clk cycles per PWM count (>=1).
REQ-004 Port clk, input, 1, single clock; all logic SHALL be in this one clock domain, rising edge.
REQ-005 Port reset_n, input, 1, reset; SHALL be asynchronous and active-low.
REQ-006 Port address, input, 3, Avalon-MM word address.
REQ-007 Port chipselect, input, 1, slave select.
REQ-008 Port write_n, input, 1, active-low write strobe.
REQ-009 Port writedata, input, 32, write data; bits above the register width SHALL be ignored.
REQ-010 Port readdata, output, 32, combinational read data, zero-extended; 0 for reserved or write-only addresses.
REQ-011 Port out_port, output, WIDTH, registered LED drive.

Function
REQ-012 A write SHALL occur on a clk edge with chipselect=1, write_n=0; zero wait states.
REQ-013 Register map: 0 DATA (R/W, WIDTH); 1 reserved; 2 SET (W, DATA |= wd); 3 CLEAR (W, DATA &= ~wd); 4 DUTY (R/W, PWM_BITS); 5 BLINK_MASK (R/W, WIDTH); 6 BLINK_HALF (R/W, 16); 7 STATUS (R: bit0 blink_phase, bit1 frame_strobe_seen, sticky).
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and assert a one-cycle tick when at PRESCALE-1, then wrap to 0.
REQ-015 pwm_cnt SHALL increment on tick and wrap from 2^PWM_BITS-1 to 0; that wrapping tick is frame_end.
REQ-016 DUTY writes SHALL load duty_pend; duty_act SHALL load duty_pend only on frame_end (glitch-free); DUTY reads return duty_pend.
REQ-017 pwm_on SHALL be 1 when pwm_cnt < duty_act, or when duty_act is all ones (100%); duty_act=0 SHALL give constant off.
REQ-018 out_port SHALL be registered as DATA & {WIDTH{pwm_on}} & ~(BLINK_MASK & {WIDTH{blink_phase}}), one cycle after its inputs change.
REQ-019 Blink frame counter SHALL increment on frame_end; on reaching BLINK_HALF it SHALL clear and toggle blink_phase.
REQ-020 BLINK_HALF=0 SHALL hold frame counter and blink_phase at 0.
REQ-021 Writing BLINK_HALF SHALL clear the frame counter and blink_phase in the same cycle.
REQ-022 STATUS bit1 SHALL set on frame_end and clear on any write to address 7; frame_end in the same cycle as the write SHALL win (bit stays set).
REQ-023 Counters SHALL never be altered by bus writes other than REQ-021.

Reset
REQ-024 On reset_n=0, DATA, duty_pend, duty_act, BLINK_MASK, BLINK_HALF, all counters, blink_phase, STATUS and out_port SHALL be 0 immediately; reset mid-frame SHALL restart the frame at pwm_cnt=0 after release.

Configuration
REQ-025 Macro LEDS_PWM_PIO_BLINK_EN defined: blink logic (REQ-019..021, BLINK_MASK, BLINK_HALF, STATUS bit0) present.
REQ-026 Macro absent: addresses 5 and 6 SHALL read 0 and ignore writes, blink_phase SHALL be constant 0, all else unchanged.

Structure
REQ-027 Package leds_pwm_pio_pkg SHALL hold register address constants (ADDR_DATA..ADDR_STATUS) and parameter defaults.
REQ-028 Sub-module leds_pwm_timebase SHALL contain prescaler and pwm_cnt, outputting pwm_cnt, tick and frame_end.

Verification (WIDTH=14, PWM_BITS=8, PRESCALE=4)
REQ-029 Reset, then DUTY=0xFF, DATA=0x2A5A -> out_port=0x2A5A from frame_end onward, readdata at addr 0 = 0x00002A5A.
REQ-030 DATA=0x0000, SET 0x0011, CLEAR 0x0001 -> DATA reads 0x0010; SET/CLEAR addresses read 0.
REQ-031 DUTY=0x40, DATA=0x3FFF -> out_port=0x3FFF for 256 clk, 0 for 768 clk per 1024-clk frame; DUTY change mid-frame applies only after frame_end.
REQ-032 BLINK_EN defined, DUTY=0xFF, BLINK_MASK=0x0003, BLINK_HALF=2, DATA=0x000F -> out_port toggles 0x000F/0x000C every 2048 clk; STATUS bit0 tracks.
REQ-033 reset_n pulsed low mid-frame with out_port nonzero -> out_port=0 asynchronously, all registers 0, pwm_cnt restarts at 0.
REQ-034 Clear STATUS (write addr 7) in the frame_end cycle -> bit1 remains 1.
